floating_point_adder: RTL and testbench
=======================================

// Module: floating_point_adder
// PURPOSE
//  Multi-cycle IEEE-754 single-precision adder/subtractor (signed add of two binary32 operands).
//  A start pulse launches one operation; the result is presented on Ans with a one-cycle done pulse.
//  Control FSM plus datapath: align by 1-bit shifts, 25-bit two's-complement add, normalize by 1-bit shifts.
//  Used as a standalone arithmetic unit driven by a simple start/done handshake.
// PARAMETERS
//  none (widths fixed: EXP_W=8, MAN_W=23, BIAS=127, carried in package)
// PORTS
//  clk    in   1   rising-edge clock; single clock domain
//  rst    in   1   reset, asynchronous, active-low
//  start  in   1   level-sampled request; honoured only in IDLE
//  Ain    in   32  operand A, binary32 {sign,exp[7:0],man[22:0]}
//  Bin    in   32  operand B, binary32
//  done   out  1   one-cycle pulse: Ans valid and updated this cycle
//  Ans    out  32  result A+B, held until next operation completes
// BEHAVIOUR
//  Reset (rst low, any time incl. mid-operation): state=IDLE, done=0, Ans=32'h0, all datapath regs 0.
//  FSM states: IDLE -> LOAD -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
//  IDLE: if start=1, go LOAD; else stay. start in any other state is ignored (no queueing).
//  LOAD: capture sign/exp/mantissa of Ain,Bin; hidden bit = (exp!=0); exp==0 operand treated as zero.
//    Order operands so the larger exponent is "big"; diff = exp_big - exp_small; counter = min(diff,25).
//  ALIGN: while counter!=0 shift small mantissa right 1 bit/cycle (bits dropped), counter--; 0 cycles if diff=0.
//  ADD: convert each 24-bit mantissa to 25-bit two's complement per its sign; sum (26-bit internal).
//    Result sign = sign of sum; magnitude = |sum| (25 bits); result exp = exp_big.
//  NORM: if magnitude==0 -> result +0 (32'h0), go DONE.
//    if bit24 set: shift right 1, exp+1 (one cycle); else while bit23==0: shift left 1, exp-1 per cycle.
//    Rounding: truncation (round toward zero); no guard/sticky bits.
//    exp reaching 255 -> result {sign,8'hFF,23'h0} (infinity). exp reaching 0 during left shift -> +0 (flush).
//  DONE: Ans <= {sign, exp, man[22:0]}; done=1 for exactly this cycle; next state IDLE.
//  Latency: start sampled in IDLE at edge 0; done high in cycle 3 + min(diff,25) + norm_shifts + 1.
//  Inf/NaN inputs (exp=255) are not special-cased; result for them is unspecified but deterministic.
//  Back-to-back: start held high through DONE re-launches immediately from IDLE next cycle.
// STRUCTURE
//  Package fpa_pkg: state enum (IDLE,LOAD,ALIGN,ADD,NORM,DONE, 3-bit), EXP_W, MAN_W, BIAS, MAX_SHIFT=25.
//  One sub-module natural: fpa_datapath (operand regs, align shifter+counter, 25-bit adder, normalizer);
//  top holds the FSM and drives datapath load/shift/count enables.
// TESTING
//  1) Ain=32'h3FE00000 (1.75), Bin=32'h405CCCCD (3.45), start 3 cycles -> done pulse once, Ans=32'h40A66666.
//  2) 32'h3F800000 + 32'hBF800000 (1.0 + -1.0) -> Ans=32'h00000000.
//  3) 32'h40400000 + 32'hBF800000 (3.0 + -1.0) -> Ans=32'h40000000 (left normalize path).
//  4) 32'h3F800000 + 32'h30800000 (1.0 + 2^-30, diff>25) -> Ans=32'h3F800000, align capped at 25 cycles.
//  5) 32'h7F7FFFFF + 32'h7F7FFFFF -> Ans=32'h7F800000 (overflow to +inf).
//  6) rst low mid-ALIGN -> done=0, Ans=0 immediately; after release, new start gives correct result.

Source files
------------

// File: rtl/fpa_pkg.sv
// Shared constants, FSM state type and binary32 field layout for the multi-cycle adder.
// Operand helpers used by the datapath to build significands and their two's-complement forms.
package fpa_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;
  localparam int MAX_SHIFT = 25;
  localparam int CNT_W     = $clog2(MAX_SHIFT + 1);

  // All-ones exponent (2*BIAS+1) encodes infinity.
  localparam logic [EXP_W-1:0] EXP_INF = EXP_W'(2 * BIAS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // A zero exponent means the operand contributes nothing (no subnormal support).
  function automatic logic [MAN_W:0] significand(input fp32_t f);
    return (f.exp != '0) ? {1'b1, f.man} : '0;
  endfunction

  function automatic logic [MAN_W+1:0] to_twos(input logic [MAN_W:0] mag, input logic neg);
    return neg ? (~{1'b0, mag} + 1'b1) : {1'b0, mag};
  endfunction

endpackage

// File: rtl/fpa_datapath.sv
// Operand registers, 1-bit/cycle align shifter with counter, 25-bit signed adder, 1-bit/cycle normaliser.
// Each stage advances only on its enable from the control FSM; ans holds until the next completion.
module fpa_datapath
  import fpa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        align_en,
  input  logic        add_en,
  input  logic        norm_en,
  input  fp32_t       ain,
  input  fp32_t       bin,
  output logic        align_skip,
  output logic        cnt_one,
  output logic        norm_done,
  output logic [31:0] ans
);

  logic             a_big;
  fp32_t            op_big;
  fp32_t            op_small;
  logic [EXP_W-1:0] diff;
  logic [CNT_W-1:0] shift_cnt;

  logic             sign_b;
  logic             sign_s;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W:0]   man_b;
  logic [MAN_W:0]   man_s;
  logic [CNT_W-1:0] cnt;

  logic [MAN_W+1:0] twos_b;
  logic [MAN_W+1:0] twos_s;
  logic [MAN_W+2:0] sum;
  logic [MAN_W+1:0] sum_mag;

  logic             res_sign;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W+1:0] res_mag;
  logic             res_zero;
  fp32_t            ans_q;

  always_comb begin
    a_big     = (ain.exp >= bin.exp);
    op_big    = a_big ? ain : bin;
    op_small  = a_big ? bin : ain;
    diff      = op_big.exp - op_small.exp;
    shift_cnt = (diff > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : diff[CNT_W-1:0];
  end

  assign align_skip = (diff == '0);
  assign cnt_one    = (cnt == CNT_W'(1));

  // Both terms fit in 25 bits signed; one extra bit keeps the sum exact.
  assign twos_b  = to_twos(man_b, sign_b);
  assign twos_s  = to_twos(man_s, sign_s);
  assign sum     = {twos_b[MAN_W+1], twos_b} + {twos_s[MAN_W+1], twos_s};
  assign sum_mag = sum[MAN_W+2] ? (~sum[MAN_W+1:0] + 1'b1) : sum[MAN_W+1:0];

  // An exponent driven to zero by left shifts flushes the result to +0.
  assign res_zero  = (res_mag == '0) || (res_exp == '0);
  assign norm_done = res_zero || (res_mag[MAN_W] && !res_mag[MAN_W+1]);
  assign ans       = ans_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_b <= 1'b0;
      sign_s <= 1'b0;
      exp_b  <= '0;
      man_b  <= '0;
      man_s  <= '0;
      cnt    <= '0;
    end else if (load) begin
      sign_b <= op_big.sign;
      sign_s <= op_small.sign;
      exp_b  <= op_big.exp;
      man_b  <= significand(op_big);
      man_s  <= significand(op_small);
      cnt    <= shift_cnt;
    end else if (align_en) begin
      man_s <= man_s >> 1;
      cnt   <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_sign <= 1'b0;
      res_exp  <= '0;
      res_mag  <= '0;
    end else if (add_en) begin
      res_sign <= sum[MAN_W+2];
      res_exp  <= exp_b;
      res_mag  <= sum_mag;
    end else if (norm_en && !norm_done) begin
      if (res_mag[MAN_W+1]) begin
        res_mag <= res_mag >> 1;
        res_exp <= res_exp + 1'b1;
      end else begin
        res_mag <= res_mag << 1;
        res_exp <= res_exp - 1'b1;
      end
    end
  end

  // Result is registered on the edge entering DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ans_q <= '0;
    end else if (norm_en && norm_done) begin
      if (res_zero)
        ans_q <= '0;
      else if (res_exp == EXP_INF)
        ans_q <= {res_sign, EXP_INF, {MAN_W{1'b0}}};
      else
        ans_q <= {res_sign, res_exp, res_mag[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/floating_point_adder.sv
// Control FSM for a multi-cycle binary32 adder; start sampled only in IDLE, ignored while busy.
// done pulses one cycle with Ans, 4 + align shifts + normalise shifts cycles after the start edge.
module floating_point_adder
  import fpa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Ain,
  input  logic [31:0] Bin,
  output logic        done,
  output logic [31:0] Ans
);

  state_t state;
  state_t state_nxt;

  logic load;
  logic align_en;
  logic add_en;
  logic norm_en;
  logic align_skip;
  logic cnt_one;
  logic norm_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = align_skip ? ADD : ALIGN;
      ALIGN:   state_nxt = cnt_one ? ADD : ALIGN;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = norm_done ? DONE : NORM;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    align_en = 1'b0;
    add_en   = 1'b0;
    norm_en  = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD:    load     = 1'b1;
      ALIGN:   align_en = 1'b1;
      ADD:     add_en   = 1'b1;
      NORM:    norm_en  = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  fpa_datapath u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .align_en   (align_en),
    .add_en     (add_en),
    .norm_en    (norm_en),
    .ain        (Ain),
    .bin        (Bin),
    .align_skip (align_skip),
    .cnt_one    (cnt_one),
    .norm_done  (norm_done),
    .ans        (Ans)
  );

endmodule

// File: tb/tb_floating_point_adder.sv
// Bench for floating_point_adder: directed cases, mid-operation reset, randomized single and back-to-back ops.
module tb_floating_point_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] Ain = 32'h0;
  logic [31:0] Bin = 32'h0;
  logic        done;
  logic [31:0] Ans;

  floating_point_adder dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Ain   (Ain),
    .Bin   (Bin),
    .done  (done),
    .Ans   (Ans)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ans;
    int          lat;
    int          launch;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          last_done = 0;
  int          launch_at = 0;
  logic [31:0] hold_ans = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: exact integer arithmetic on significands, truncation, leading-one search.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    int ea, eb, ma, mb, sh, e, sum, mag, p, k, n;
    logic neg;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea != 0) ? int'({1'b1, a[22:0]}) : 0;
    mb = (eb != 0) ? int'({1'b1, b[22:0]}) : 0;
    if (ea >= eb) begin sh = ea - eb; e = ea; end
    else begin sh = eb - ea; e = eb; end
    if (sh > 25) sh = 25;
    if (ea >= eb) mb = mb >> sh;
    else ma = ma >> sh;
    sum = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
    neg = (sum < 0);
    mag = neg ? -sum : sum;
    n = 0;
    r = 32'h0;
    if (mag != 0) begin
      p = 0;
      for (int i = 0; i < 26; i++) if (mag[i]) p = i;
      if (p == 24) begin
        n = 1;
        e = e + 1;
        mag = mag >> 1;
        r = (e >= 255) ? {neg, 8'hFF, 23'h0} : {neg, 8'(e), 23'(mag)};
      end else begin
        k = 23 - p;
        if (k >= e) n = e;
        else begin
          n = k;
          e = e - k;
          mag = mag << k;
          r = {neg, 8'(e), 23'(mag)};
        end
      end
    end
    lat = sh + n + 4;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  // Compare process: every cycle out of reset, Ans must hold or match the next expected completion.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      hold_ans = 32'h0;
    end else if (done) begin
      if (q.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'h0);
      end else begin
        cur = q.pop_front();
        launch_at = (cur.launch < 0) ? last_done + 1 : cur.launch;
        check("ans", Ans, cur.ans);
        check("latency", cyc - launch_at, cur.lat);
        hold_ans = cur.ans;
        last_done = cyc;
      end
    end else begin
      check("ans_hold", Ans, hold_ans);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", q.size(), 32'h0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int lat, input int hold);
    tick();
    Ain = a;
    Bin = b;
    start = 1'b1;
    q.push_back('{ans: want, lat: lat, launch: cyc});
    repeat (hold) tick();
    start = 1'b0;
    wait_drain(60);
  endtask

  task automatic run_rand(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] w;
    int l;
    model(a, b, w, l);
    run_op(a, b, w, l, $urandom_range(1, 3));
  endtask

  // start stays high through the first DONE, so the second op launches straight from IDLE.
  task automatic run_b2b(input logic [31:0] a1, input logic [31:0] b1,
                         input logic [31:0] a2, input logic [31:0] b2);
    logic [31:0] w1, w2;
    int l1, l2, n;
    model(a1, b1, w1, l1);
    model(a2, b2, w2, l2);
    tick();
    Ain = a1;
    Bin = b1;
    start = 1'b1;
    q.push_back('{ans: w1, lat: l1, launch: cyc});
    q.push_back('{ans: w2, lat: l2, launch: -1});
    n = 0;
    while (q.size() == 2 && n < 60) begin
      tick();
      n++;
    end
    Ain = a2;
    Bin = b2;
    tick();
    tick();
    start = 1'b0;
    wait_drain(60);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] w, a, b;
    int l, mode, ea, eb;

    #2 rst = 1'b0;
    repeat (3) tick();
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_ans", Ans, 32'h0);
    rst = 1'b1;

    model(32'h3FE00000, 32'h405CCCCD, w, l);
    check("model_t1", w, 32'h40A66666);
    check("model_t1_lat", l, 32'd6);
    model(32'h3F800000, 32'hBF800000, w, l);
    check("model_cancel", w, 32'h00000000);
    model(32'h40400000, 32'hBF800000, w, l);
    check("model_leftnorm", w, 32'h40000000);
    model(32'h3F800000, 32'h30800000, w, l);
    check("model_bigdiff_lat", l, 32'd29);
    model(32'h7F7FFFFF, 32'h7F7FFFFF, w, l);
    check("model_overflow", w, 32'h7F800000);
    model(32'h00800000, 32'h80C00000, w, l);
    check("model_flush", w, 32'h00000000);
    check("model_flush_lat", l, 32'd5);

    run_op(32'h3FE00000, 32'h405CCCCD, 32'h40A66666, 6, 3);
    run_op(32'h3F800000, 32'hBF800000, 32'h00000000, 4, 1);
    run_op(32'h40400000, 32'hBF800000, 32'h40000000, 5, 1);
    run_op(32'h3F800000, 32'h30800000, 32'h3F800000, 29, 1);
    run_op(32'h00800000, 32'h80C00000, 32'h00000000, 5, 1);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, 2);

    // Reset in the middle of a 25-cycle alignment.
    tick();
    Ain = 32'h3F800000;
    Bin = 32'h30800000;
    start = 1'b1;
    q.push_back('{ans: 32'h3F800000, lat: 29, launch: cyc});
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("rst_mid_done", {31'b0, done}, 32'h0);
    check("rst_mid_ans", Ans, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    run_op(32'h40400000, 32'hBF800000, 32'h40000000, 5, 1);
    run_b2b(32'h3FE00000, 32'h405CCCCD, 32'h3F800000, 32'hBF800000);

    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 4);
      a = $urandom;
      b = $urandom;
      ea = $urandom_range(1, 254);
      case (mode)
        0: eb = $urandom_range(0, 254);
        1: begin
          eb = ea + int'($urandom_range(0, 4)) - 2;
          b[31] = ~a[31];
          b[22:8] = a[22:8];
        end
        2: begin
          ea = $urandom_range(248, 254);
          eb = $urandom_range(248, 254);
        end
        3: begin
          ea = $urandom_range(1, 6);
          eb = $urandom_range(1, 6);
          b[31] = ~a[31];
        end
        default: eb = 0;
      endcase
      if (eb < 0) eb = 0;
      if (eb > 254) eb = 254;
      a[30:23] = 8'(ea);
      b[30:23] = 8'(eb);
      if (i % 5 == 4) run_b2b(a, b, rnd_fp(), rnd_fp());
      else run_rand(a, b);
    end

    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
